// File: rtl/ov7670_pkg.sv
// Shared definitions for the OV7670 SCCB boot-time configuration sequencer.
// Optional readback compare is enabled with the SCCB_READBACK_EN macro.
package ov7670_pkg;

    // Sequencer states; bus states are StStart..StGap.
    typedef enum logic [3:0] {
        StIdle,
        StBootWait,
        StFetch,
        StDecode,
        StDelay,
        StStart,
        StBits,
        StStop,
        StGap
    } sccb_state_e;

    // Which transaction of an entry is on the bus (only write without readback).
    typedef enum logic [1:0] {
        PhWrite,
        PhRdWr,
        PhRd
    } sccb_phase_e;

    localparam logic [15:0] ROM_END     = 16'hFFFF;
    localparam logic [7:0]  ROM_DLY     = 8'hF0;
    localparam logic [7:0]  REG_COM7    = 8'h12;
    localparam logic [7:0]  SCCB_RD_BIT = 8'h01;

    // Full 3-phase write frame and the shorter 2-phase frames, in bits.
    localparam int unsigned FRAME_W    = 27;
    localparam int unsigned SHORT_BITS = 18;
    localparam int unsigned GAP_QTRS   = 8;

    // Pack three bytes MSB first, each followed by a released (1) don't-care bit.
    function automatic logic [FRAME_W-1:0] sccb_frame(input logic [7:0] b0,
                                                      input logic [7:0] b1,
                                                      input logic [7:0] b2);
        return {b0, 1'b1, b1, 1'b1, b2, 1'b1};
    endfunction

endpackage

// File: rtl/ov7670_reg_rom.sv
// Register table for the OV7670: {addr, data} per entry, 16'hF0nn = wait nn ms,
// 16'hFFFF = end of table. Registered output, one cycle of latency.
module ov7670_reg_rom
    import ov7670_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] idx,
    output logic [15:0]      q
);

    // Synchronous table lookup; anything past the last entry reads as the end marker.
    always_ff @(posedge clk) begin
        case (idx)
            IDX_W'(0): q <= 16'h1280;  // COM7: soft reset of all registers
            IDX_W'(1): q <= 16'hF001;  // let the sensor finish its soft reset
            IDX_W'(2): q <= 16'h40D0;  // COM15: full output range, RGB565
            IDX_W'(3): q <= ROM_END;
            default:   q <= ROM_END;
        endcase
    end

endmodule

// File: rtl/ov7670_sccb_config.sv
// OV7670 boot-time configuration sequencer: waits for sensor power-up, then issues one
// SCCB write per ROM entry and raises done at the end marker.
// Define SCCB_READBACK_EN to read every written register back and flag mismatches.
module ov7670_sccb_config
    import ov7670_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned SCCB_HZ  = 100_000,
    parameter logic [7:0]  DEV_ADDR = 8'h42,
    parameter int unsigned BOOT_MS  = 5,
    parameter int unsigned IDX_W    = 8
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             start,
    output logic             sioc,
    output logic             siod_oe,
    input  logic             siod_in,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IDX_W-1:0] reg_idx
);

    localparam int unsigned QTR      = CLK_HZ / (4 * SCCB_HZ);
    localparam int unsigned MS_CYC   = CLK_HZ / 1000;
    localparam int unsigned BOOT_CYC = BOOT_MS * MS_CYC;
    localparam int unsigned QCNT_W   = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QCNT_W-1:0] QTR_LAST = QCNT_W'(QTR - 1);

    sccb_state_e        state_q;
    logic [QCNT_W-1:0]  qcnt_q;
    logic [1:0]         qph_q;
    logic [4:0]         bit_no_q;
    logic [4:0]         last_bit_q;
    logic [FRAME_W-1:0] frame_q;
    logic [31:0]        wait_cnt_q;
    logic [15:0]        rom_q;
    logic               bus_act;
    logic               tick;
    logic               last_idx;

`ifdef SCCB_READBACK_EN
    sccb_phase_e        phase_q;
    logic [15:0]        ent_q;
    logic [7:0]         rd_q;
    logic               error_q;

    assign error = error_q;
`else
    logic               unused_siod_in;

    assign unused_siod_in = siod_in;
    assign error          = 1'b0;
`endif

    ov7670_reg_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .clk (clk_50),
        .idx (reg_idx),
        .q   (rom_q)
    );

    assign bus_act  = (state_q inside {StStart, StBits, StStop, StGap});
    assign tick     = bus_act && (qcnt_q == QTR_LAST);
    // The last index never wraps; it is treated as the end of the table.
    assign last_idx = &reg_idx;

    // Quarter-bit timer: free-runs only while the bus is active, idles at zero.
    always_ff @(posedge clk_50) begin
        if (!reset_n || !bus_act) begin
            qcnt_q <= '0;
            qph_q  <= 2'd0;
        end else if (tick) begin
            qcnt_q <= '0;
            qph_q  <= qph_q + 2'd1;
        end else begin
            qcnt_q <= qcnt_q + 1'b1;
        end
    end

    // Sequencer FSM with registered bus outputs; all bus changes land on quarter ticks.
    always_ff @(posedge clk_50) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            sioc       <= 1'b1;
            siod_oe    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            reg_idx    <= '0;
            bit_no_q   <= '0;
            last_bit_q <= '0;
            frame_q    <= '0;
            wait_cnt_q <= '0;
`ifdef SCCB_READBACK_EN
            phase_q    <= PhWrite;
            ent_q      <= '0;
            rd_q       <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        reg_idx    <= '0;
                        wait_cnt_q <= 32'(BOOT_CYC);
`ifdef SCCB_READBACK_EN
                        error_q    <= 1'b0;
`endif
                        state_q    <= StBootWait;
                    end
                end

                StBootWait: begin
                    if (wait_cnt_q <= 32'd1) begin
                        state_q <= StFetch;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 32'd1;
                    end
                end

                // ROM address was set on entry; its registered output is valid next cycle.
                StFetch: state_q <= StDecode;

                StDecode: begin
                    if (rom_q == ROM_END) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end else if (rom_q[15:8] == ROM_DLY) begin
                        wait_cnt_q <= 32'(rom_q[7:0]) * 32'(MS_CYC);
                        state_q    <= StDelay;
                    end else begin
                        frame_q    <= sccb_frame(DEV_ADDR, rom_q[15:8], rom_q[7:0]);
                        last_bit_q <= 5'(FRAME_W - 1);
                        sioc       <= 1'b1;
                        siod_oe    <= 1'b0;
`ifdef SCCB_READBACK_EN
                        ent_q      <= rom_q;
                        phase_q    <= PhWrite;
`endif
                        state_q    <= StStart;
                    end
                end

                StDelay: begin
                    if (wait_cnt_q <= 32'd1) begin
                        if (last_idx) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            reg_idx <= reg_idx + 1'b1;
                            state_q <= StFetch;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 32'd1;
                    end
                end

                // SIOD falls in q1 while SIOC is high, SIOC drops in q3.
                StStart: begin
                    if (tick) begin
                        case (qph_q)
                            2'd0: siod_oe <= 1'b1;
                            2'd2: sioc    <= 1'b0;
                            2'd3: begin
                                sioc     <= 1'b0;
                                siod_oe  <= ~frame_q[FRAME_W-1];
                                bit_no_q <= '0;
                                state_q  <= StBits;
                            end
                            default: ;
                        endcase
                    end
                end

                // Data set up in q0/q1 with SIOC low, SIOC high through q2/q3.
                StBits: begin
                    if (tick) begin
                        case (qph_q)
                            2'd1: sioc <= 1'b1;
`ifdef SCCB_READBACK_EN
                            2'd2: begin
                                if (phase_q == PhRd && bit_no_q >= 5'd9 && bit_no_q <= 5'd16) begin
                                    rd_q <= {rd_q[6:0], siod_in};
                                end
                            end
`endif
                            2'd3: begin
                                sioc <= 1'b0;
                                if (bit_no_q == last_bit_q) begin
                                    siod_oe <= 1'b1;
                                    state_q <= StStop;
                                end else begin
                                    siod_oe  <= ~frame_q[FRAME_W-2];
                                    frame_q  <= {frame_q[FRAME_W-2:0], 1'b1};
                                    bit_no_q <= bit_no_q + 5'd1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                // SIOC rises in q1, SIOD is released in q3 while SIOC is high.
                StStop: begin
                    if (tick) begin
                        case (qph_q)
                            2'd0: sioc    <= 1'b1;
                            2'd2: siod_oe <= 1'b0;
                            2'd3: begin
                                bit_no_q <= '0;
                                state_q  <= StGap;
                            end
                            default: ;
                        endcase
                    end
                end

                // Bus free time between transactions, counted in quarters.
                StGap: begin
                    if (tick) begin
                        if (bit_no_q == 5'(GAP_QTRS - 1)) begin
`ifdef SCCB_READBACK_EN
                            if (phase_q == PhWrite && ent_q[15:8] != REG_COM7) begin
                                frame_q    <= sccb_frame(DEV_ADDR, ent_q[15:8], 8'hFF);
                                last_bit_q <= 5'(SHORT_BITS - 1);
                                phase_q    <= PhRdWr;
                                state_q    <= StStart;
                            end else if (phase_q == PhRdWr) begin
                                frame_q    <= sccb_frame(DEV_ADDR | SCCB_RD_BIT, 8'hFF, 8'hFF);
                                last_bit_q <= 5'(SHORT_BITS - 1);
                                phase_q    <= PhRd;
                                state_q    <= StStart;
                            end else if (phase_q == PhRd && rd_q != ent_q[7:0]) begin
                                // reg_idx is left pointing at the failing entry.
                                error_q <= 1'b1;
                                busy    <= 1'b0;
                                state_q <= StIdle;
                            end else
`endif
                            if (last_idx) begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                reg_idx <= reg_idx + 1'b1;
                                state_q <= StFetch;
                            end
                        end else begin
                            bit_no_q <= bit_no_q + 5'd1;
                        end
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
